vr_rr_arbiter: RTL and testbench

// - Shares one valid/ready byte stream (the no-FIFO pipeline stage) among N_REQ upstream requesters.
// - Round-robin arbitration per transfer, plus one registered output stage; no buffering beyond that stage.
// - Sits between the requesters and the downstream valid/ready consumer; drives its din/valid_i/ready_o contract.

---
 rtl/vr_rr_arbiter.sv | 97 +++++++++
 tb/tb_vr_rr_arbiter.sv | 138 +++++++++++++
 2 files changed

// File: rtl/vr_rr_arbiter.sv
// Round-robin arbiter sharing one registered valid/ready byte stage among N_REQ requesters.
// Optional macro VR_ARB_BURST_EN lets a granted requester keep the grant for up to MAX_BURST beats.
module vr_rr_arbiter #(
  parameter int unsigned N_REQ     = 4,
  parameter int unsigned DW        = 8,
  parameter int unsigned IDW       = 2,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_REQ-1:0]      valid_i,
  input  logic [N_REQ*DW-1:0]   din,
  output logic [N_REQ-1:0]      ready_o,
  output logic                  valid_o,
  output logic [DW-1:0]         dout,
  output logic [IDW-1:0]        gnt_id_o,
  input  logic                  ready_i
);

  logic           load;
  logic           take;
  logic           any;
  logic [IDW-1:0] grant;
  logic [IDW-1:0] idx;
  logic [IDW-1:0] ptr;

`ifdef VR_ARB_BURST_EN
  localparam int unsigned BCW = 8;
  logic [BCW-1:0] burst_cnt;
  logic [BCW-1:0] burst_nxt;
`endif

  // Downward scan so the requester closest after ptr is written last and wins.
  always_comb begin
    grant = '0;
    any   = 1'b0;
    idx   = '0;
    for (int i = N_REQ; i >= 1; i--) begin
      idx = IDW'((32'(ptr) + 32'(i)) % N_REQ);
      if (valid_i[idx]) begin
        grant = idx;
        any   = 1'b1;
      end
    end
`ifdef VR_ARB_BURST_EN
    if (burst_cnt != '0 && valid_i[ptr]) begin
      grant = ptr;
      any   = 1'b1;
    end
`endif
  end

  assign load = ~valid_o | ready_i;
  assign take = load & any & ~rst;

  always_comb begin
    ready_o = '0;
    if (take) ready_o[grant] = 1'b1;
  end

`ifdef VR_ARB_BURST_EN
  // Count beats of the current grant; a full burst releases the grant.
  always_comb begin
    burst_nxt = (burst_cnt != '0 && grant == ptr) ? burst_cnt + BCW'(1) : BCW'(1);
    if (burst_nxt == BCW'(MAX_BURST)) burst_nxt = '0;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_o  <= 1'b0;
      dout     <= '0;
      gnt_id_o <= '0;
      ptr      <= IDW'(N_REQ - 1);
`ifdef VR_ARB_BURST_EN
      burst_cnt <= '0;
`endif
    end else begin
      if (load) begin
        valid_o <= any;
        if (any) begin
          dout     <= din[32'(grant)*DW +: DW];
          gnt_id_o <= grant;
          ptr      <= grant;
        end
      end
`ifdef VR_ARB_BURST_EN
      if (take) begin
        burst_cnt <= burst_nxt;
      end else if (burst_cnt != '0 && !valid_i[ptr]) begin
        burst_cnt <= '0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_vr_rr_arbiter.sv
// Directed bench for vr_rr_arbiter (default build, strict round-robin, N_REQ=4, DW=8).
module tb_vr_rr_arbiter;

  localparam int unsigned N_REQ = 4;
  localparam int unsigned DW    = 8;
  localparam int unsigned IDW   = 2;

  logic                clk = 1'b0;
  logic                rst;
  logic [N_REQ-1:0]    valid_i;
  logic [N_REQ*DW-1:0] din;
  logic [N_REQ-1:0]    ready_o;
  logic                valid_o;
  logic [DW-1:0]       dout;
  logic [IDW-1:0]      gnt_id_o;
  logic                ready_i;

  int total = 0;
  int bad   = 0;

  vr_rr_arbiter #(.N_REQ(N_REQ), .DW(DW), .IDW(IDW), .MAX_BURST(4)) dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .din(din), .ready_o(ready_o),
    .valid_o(valid_o), .dout(dout), .gnt_id_o(gnt_id_o), .ready_i(ready_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [3:0] v;
    logic       rdy;
    logic [7:0] base;
    logic [3:0] e_ro;
    logic       e_vo;
    logic [7:0] e_dout;
    logic [1:0] e_gnt;
  } vec_t;

  vec_t tbl [18];

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  // Requester k presents base+k.
  task automatic set_din(input logic [7:0] base);
    for (int k = 0; k < N_REQ; k++) din[k*DW +: DW] = 8'(base + 8'(k));
  endtask

  initial begin
    rst = 1'b1; valid_i = '0; ready_i = 1'b1; din = '0;

    //          rst   v      rdy   base  e_ro   e_vo e_dout e_gnt
    tbl[0]  = '{1'b1, 4'hf, 1'b1, 8'd0,   4'h0, 1'b0, 8'd0,   2'd0};
    tbl[1]  = '{1'b0, 4'hf, 1'b1, 8'd10,  4'h1, 1'b1, 8'd10,  2'd0};
    tbl[2]  = '{1'b0, 4'hf, 1'b1, 8'd20,  4'h2, 1'b1, 8'd21,  2'd1};
    tbl[3]  = '{1'b0, 4'hf, 1'b1, 8'd30,  4'h4, 1'b1, 8'd32,  2'd2};
    tbl[4]  = '{1'b0, 4'hf, 1'b0, 8'd40,  4'h0, 1'b1, 8'd32,  2'd2};
    tbl[5]  = '{1'b0, 4'hf, 1'b0, 8'd50,  4'h0, 1'b1, 8'd32,  2'd2};
    tbl[6]  = '{1'b0, 4'hf, 1'b1, 8'd60,  4'h8, 1'b1, 8'd63,  2'd3};
    tbl[7]  = '{1'b0, 4'hf, 1'b1, 8'd70,  4'h1, 1'b1, 8'd70,  2'd0};
    tbl[8]  = '{1'b0, 4'h9, 1'b1, 8'd80,  4'h8, 1'b1, 8'd83,  2'd3};
    tbl[9]  = '{1'b0, 4'h9, 1'b1, 8'd90,  4'h1, 1'b1, 8'd90,  2'd0};
    tbl[10] = '{1'b0, 4'h9, 1'b1, 8'd100, 4'h8, 1'b1, 8'd103, 2'd3};
    tbl[11] = '{1'b0, 4'h0, 1'b1, 8'd110, 4'h0, 1'b0, 8'd103, 2'd3};
    tbl[12] = '{1'b0, 4'h0, 1'b0, 8'd115, 4'h0, 1'b0, 8'd103, 2'd3};
    tbl[13] = '{1'b0, 4'h2, 1'b0, 8'd120, 4'h2, 1'b1, 8'd121, 2'd1};
    tbl[14] = '{1'b0, 4'hf, 1'b0, 8'd130, 4'h0, 1'b1, 8'd121, 2'd1};
    tbl[15] = '{1'b1, 4'hf, 1'b0, 8'd140, 4'h0, 1'b0, 8'd0,   2'd0};
    tbl[16] = '{1'b0, 4'h6, 1'b1, 8'd150, 4'h2, 1'b1, 8'd151, 2'd1};
    tbl[17] = '{1'b0, 4'h4, 1'b1, 8'd160, 4'h4, 1'b1, 8'd162, 2'd2};

    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      rst = tbl[i].rst; valid_i = tbl[i].v; ready_i = tbl[i].rdy; set_din(tbl[i].base);
      #1 chk("ready_o", i, 32'(ready_o), 32'(tbl[i].e_ro));
      @(posedge clk); #1;
      chk("valid_o", i, 32'(valid_o), 32'(tbl[i].e_vo));
      chk("dout", i, 32'(dout), 32'(tbl[i].e_dout));
      chk("gnt_id_o", i, 32'(gnt_id_o), 32'(tbl[i].e_gnt));
    end

    // Single requester 1 with counting data.
    @(negedge clk); rst = 1'b1; valid_i = '0; ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      rst = 1'b0; valid_i = 4'b0010; din = '0; din[1*DW +: DW] = 8'(i);
      #1 chk("single_ready", i, 32'(ready_o), 32'h2);
      @(posedge clk); #1;
      chk("single_dout", i, 32'(dout), 32'(i));
      chk("single_gnt", i, 32'(gnt_id_o), 32'd1);
    end

    // All valid: full rotation, long stall, resume without loss or duplication.
    @(negedge clk); rst = 1'b1; valid_i = '0;
    @(negedge clk); rst = 1'b0; valid_i = 4'hf; ready_i = 1'b1; set_din(8'h40);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      chk("rot_gnt", i, 32'(gnt_id_o), 32'(i % 4));
      chk("rot_valid", i, 32'(valid_o), 32'd1);
      chk("rot_dout", i, 32'(dout), 32'(8'h40 + 8'(i % 4)));
    end
    @(negedge clk); ready_i = 1'b0;
    for (int i = 0; i < 15; i++) begin
      #1 chk("stall_ready", i, 32'(ready_o), 32'h0);
      @(posedge clk); #1;
      chk("stall_gnt", i, 32'(gnt_id_o), 32'd1);
      chk("stall_dout", i, 32'(dout), 32'h41);
      @(negedge clk);
    end
    ready_i = 1'b1;
    #1 chk("resume_ready", 0, 32'(ready_o), 32'h4);
    @(posedge clk); #1;
    chk("resume_gnt", 0, 32'(gnt_id_o), 32'd2);
    chk("resume_dout", 0, 32'(dout), 32'h42);
    @(posedge clk); #1;
    chk("resume_gnt", 1, 32'(gnt_id_o), 32'd3);

    // Reset mid-stream discards the held beat; priority returns to requester 0.
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_valid", 0, 32'(valid_o), 32'd0);
    chk("midrst_dout", 0, 32'(dout), 32'd0);
    chk("midrst_gnt", 0, 32'(gnt_id_o), 32'd0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    chk("midrst_next", 0, 32'(gnt_id_o), 32'd0);
    chk("midrst_next_dout", 0, 32'(dout), 32'h40);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
